dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 37 +++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two-master data-memory port bundle
// The arbiter takes the slave modport; the masters/memory side takes master.
interface dmem_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic [3:0]  m0_we;
    logic [3:0]  m1_we;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic        m1_lock;
    logic        m0_gnt;
    logic        m1_gnt;
    logic        m0_rvalid;
    logic        m1_rvalid;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
        input  m0_wdata, m1_wdata, m1_lock, mem_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
        output m0_wdata, m1_wdata, m1_lock, mem_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - m0-priority data-memory arbiter with m1 anti-starvation and lock
// Grants are combinational; read ownership is tracked one cycle to steer rvalid/rdata.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rd_own0_q, rd_own0_d;
    logic       rd_own1_q, rd_own1_d;
    logic       gnt0, gnt1;

    // Grants are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (state_q == LOCK1) begin
                gnt1 = bus.m1_req;
            end else if (bus.m0_req && !(bus.m1_req && (starve_cnt_q == LIMIT))) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = bus.m1_req;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        rd_own0_d    = gnt0 && (bus.m0_we == 4'b0000);
        rd_own1_d    = gnt1 && (bus.m1_we == 4'b0000);

        case (state_q)
            ARB: begin
                if (gnt1 && bus.m1_lock) state_d = LOCK1;
            end
            LOCK1: begin
                if ((gnt1 && !bus.m1_lock) || !bus.m1_req) state_d = ARB;
            end
            default: state_d = ARB;
        endcase

        if (!bus.m1_req || gnt1) begin
            starve_cnt_d = 4'd0;
        end else if (gnt0 && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            starve_cnt_q <= 4'd0;
            rd_own0_q    <= 1'b0;
            rd_own1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_own0_q    <= rd_own0_d;
            rd_own1_q    <= rd_own1_d;
        end
    end

    always_comb begin
        bus.m0_gnt    = gnt0;
        bus.m1_gnt    = gnt1;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        if (gnt0) begin
            bus.mem_we    = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
        end else if (gnt1) begin
            bus.mem_we    = bus.m1_we;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
        end
    end

    // Memory returns read data one cycle after the address, so the owner flag lines up.
    always_comb begin
        bus.m0_rvalid = rd_own0_q;
        bus.m1_rvalid = rd_own1_q;
        bus.m0_rdata  = rd_own0_q ? bus.mem_rdata : 32'h0;
        bus.m1_rdata  = rd_own1_q ? bus.mem_rdata : 32'h0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a transaction-level model
module tb_dmem_arbiter;
    localparam int LIMIT = 8;

    typedef struct {
        logic        g0, g1, v0, v1;
        logic [31:0] d0, d1;
        logic [3:0]  mwe;
        logic [31:0] maddr, mwdata;
    } exp_t;

    logic clk;
    logic rst_n;
    dmem_arbiter_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic        in_rst_n = 1'b0;
    logic        in_r0 = 1'b0, in_r1 = 1'b0, in_lock = 1'b0;
    logic [3:0]  in_w0 = 4'h0, in_w1 = 4'h0;
    logic [31:0] in_a0 = 32'h0, in_a1 = 32'h0, in_d0 = 32'h0, in_d1 = 32'h0;
    logic [31:0] in_mem_rdata = 32'h0;

    // Model state: who owns the bus after a lock, how long m1 has been losing, pending reads.
    bit mdl_locked = 1'b0;
    int mdl_m1_losses = 0;
    bit mdl_pend0 = 1'b0, mdl_pend1 = 1'b0;
    bit last_g0, last_g1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        rst_n         = in_rst_n;
        bus.m0_req    = in_r0;
        bus.m1_req    = in_r1;
        bus.m0_we     = in_w0;
        bus.m1_we     = in_w1;
        bus.m0_addr   = in_a0;
        bus.m1_addr   = in_a1;
        bus.m0_wdata  = in_d0;
        bus.m1_wdata  = in_d1;
        bus.m1_lock   = in_lock;
        bus.mem_rdata = in_mem_rdata;
        e = '{g0: 1'b0, g1: 1'b0, v0: 1'b0, v1: 1'b0, d0: 32'h0, d1: 32'h0,
              mwe: 4'h0, maddr: 32'h0, mwdata: 32'h0};
        if (!in_rst_n) begin
            mdl_locked    = 1'b0;
            mdl_m1_losses = 0;
            mdl_pend0     = 1'b0;
            mdl_pend1     = 1'b0;
        end else begin
            e.v0 = mdl_pend0;
            e.v1 = mdl_pend1;
            if (mdl_pend0) e.d0 = in_mem_rdata;
            if (mdl_pend1) e.d1 = in_mem_rdata;
            if (mdl_locked)
                e.g1 = in_r1;
            else if (in_r1 && (!in_r0 || mdl_m1_losses >= LIMIT))
                e.g1 = 1'b1;
            else
                e.g0 = in_r0;
            if (e.g0) begin
                e.mwe = in_w0; e.maddr = in_a0; e.mwdata = in_d0;
            end else if (e.g1) begin
                e.mwe = in_w1; e.maddr = in_a1; e.mwdata = in_d1;
            end
            mdl_pend0 = e.g0 && (in_w0 == 4'h0);
            mdl_pend1 = e.g1 && (in_w1 == 4'h0);
            if (in_r1 && !e.g1)
                mdl_m1_losses = (mdl_m1_losses + 1 > LIMIT) ? LIMIT : mdl_m1_losses + 1;
            else
                mdl_m1_losses = 0;
            if (e.g1)
                mdl_locked = in_lock;
            else if (!in_r1)
                mdl_locked = 1'b0;
        end
        last_g0 = e.g0;
        last_g1 = e.g1;
        exp_q.push_back(e);
    endtask

    // Monitor: samples a few ns after inputs settle, well before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m0_gnt",    {31'h0, bus.m0_gnt},    {31'h0, e.g0});
                chk("m1_gnt",    {31'h0, bus.m1_gnt},    {31'h0, e.g1});
                chk("m0_rvalid", {31'h0, bus.m0_rvalid}, {31'h0, e.v0});
                chk("m1_rvalid", {31'h0, bus.m1_rvalid}, {31'h0, e.v1});
                chk("m0_rdata",  bus.m0_rdata,  e.d0);
                chk("m1_rdata",  bus.m1_rdata,  e.d1);
                chk("mem_we",    {28'h0, bus.mem_we}, {28'h0, e.mwe});
                chk("mem_addr",  bus.mem_addr,  e.maddr);
                chk("mem_wdata", bus.mem_wdata, e.mwdata);
            end
        end
    end

    initial begin
        int m1_wins;
        int m0_run;
        rst_n = 1'b0;
        bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m1_lock = 1'b0;
        bus.m0_we = 4'h0; bus.m1_we = 4'h0;
        bus.m0_addr = 32'h0; bus.m1_addr = 32'h0;
        bus.m0_wdata = 32'h0; bus.m1_wdata = 32'h0; bus.mem_rdata = 32'h0;

        // Reset with a read request pending on both masters.
        in_r0 = 1'b1; in_r1 = 1'b1;
        repeat (2) cycle();
        in_rst_n = 1'b1;
        in_r0 = 1'b0; in_r1 = 1'b0;
        cycle();

        // Single m0 read followed by its data beat.
        in_r0 = 1'b1; in_w0 = 4'h0; in_a0 = 32'h100;
        cycle();
        in_r0 = 1'b0; in_mem_rdata = 32'hDEADBEEF;
        cycle();
        in_mem_rdata = 32'h0;

        // m0 single-lane write.
        in_r0 = 1'b1; in_w0 = 4'b0100; in_a0 = 32'h204; in_d0 = 32'h00AB0000;
        cycle();
        in_r0 = 1'b0;
        cycle();

        // Both masters request continuously: m1 should win once every LIMIT+1 cycles.
        in_r0 = 1'b1; in_w0 = 4'h0; in_a0 = 32'h300;
        in_r1 = 1'b1; in_w1 = 4'h0; in_a1 = 32'h400;
        m1_wins = 0; m0_run = 0;
        for (int i = 0; i < 3 * (LIMIT + 1); i++) begin
            in_mem_rdata = $urandom;
            cycle();
            if (last_g1) begin
                m1_wins++;
                chk("starve_run", m0_run, LIMIT);
                m0_run = 0;
            end else begin
                m0_run++;
            end
        end
        chk("starve_m1_wins", m1_wins, 3);
        in_r0 = 1'b0; in_r1 = 1'b0;
        cycle();

        // m1 locked burst against a waiting m0.
        in_r1 = 1'b1; in_lock = 1'b1; in_w1 = 4'hF; in_a1 = 32'h500; in_d1 = 32'h11111111;
        cycle();
        in_r0 = 1'b1; in_w0 = 4'h0; in_a0 = 32'h600;
        in_d1 = 32'h22222222;
        cycle();
        in_lock = 1'b0; in_d1 = 32'h33333333;
        cycle();
        in_r1 = 1'b0;
        cycle();
        in_r0 = 1'b0;
        cycle();

        // Reset mid-lock with an m1 read in flight; both request on release.
        in_r1 = 1'b1; in_lock = 1'b1; in_w1 = 4'h0; in_a1 = 32'h700;
        cycle();
        in_r0 = 1'b1;
        cycle();
        in_rst_n = 1'b0; in_mem_rdata = 32'hCAFEF00D;
        cycle();
        cycle();
        in_rst_n = 1'b1;
        cycle();
        in_r0 = 1'b0; in_r1 = 1'b0; in_lock = 1'b0;
        cycle();

        // Randomised traffic; requests stay held until the model grants them.
        for (int i = 0; i < 3000; i++) begin
            if (!in_r0 && $urandom_range(0, 2) != 0) begin
                in_r0 = 1'b1;
                in_w0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                in_a0 = $urandom; in_d0 = $urandom;
            end
            if (!in_r1 && $urandom_range(0, 2) != 0) begin
                in_r1 = 1'b1;
                in_w1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                in_a1 = $urandom; in_d1 = $urandom;
            end
            in_lock = ($urandom_range(0, 3) == 0);
            in_rst_n = ($urandom_range(0, 199) != 0);
            in_mem_rdata = $urandom;
            cycle();
            if (last_g0 || !in_rst_n) in_r0 = 1'b0;
            if (last_g1 || !in_rst_n) in_r1 = 1'b0;
        end

        in_rst_n = 1'b1; in_r0 = 1'b0; in_r1 = 1'b0;
        cycle();
        @(negedge clk);
        #6;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
